// File: rtl/usb_rx_word_assembler_if.sv
// Byte-in / word-out handshake bundle for the USB RX word assembler.
// master drives received bytes and consumer ready; slave is the assembler.
interface usb_rx_word_assembler_if;
  logic        byte_valid;
  logic        new_packet;
  logic [7:0]  data_in;
  logic        output_ready;
  logic [31:0] stock_data;
  logic        data_ready;
  logic        overrun;
  logic        frame_error;

  modport master (
    output byte_valid, new_packet, data_in, output_ready,
    input  stock_data, data_ready, overrun, frame_error
  );

  modport slave (
    input  byte_valid, new_packet, data_in, output_ready,
    output stock_data, data_ready, overrun, frame_error
  );
endinterface

// File: rtl/usb_rx_word_assembler.sv
// Packs USB payload bytes big-endian into 32-bit words, buffers them in a
// 2-entry FIFO and flags overruns, stray bytes and mid-word idle timeouts.
module usb_rx_word_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  usb_rx_word_assembler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [23:0] hold_q, hold_d;
  logic [15:0] idle_q, idle_d;
  logic        push, fe_d, pop;
  logic [31:0] push_word;

  logic [31:0] ent0_q, ent1_q;
  logic [1:0]  cnt_q;
  logic        ovr_q, fe_q;

  // Assembler: held bytes live in hold_q, 4th byte completes straight from data_in
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idle_d    = idle_q;
    push      = 1'b0;
    fe_d      = 1'b0;
    push_word = {hold_q, bus.data_in};
    if (state_q == IDLE) begin
      idle_d = '0;
      if (bus.byte_valid) begin
        if (bus.new_packet) begin
          hold_d[23:16] = bus.data_in;
          state_d       = B1;
        end else begin
          fe_d = 1'b1;
        end
      end
    end else if (bus.byte_valid) begin
      idle_d = '0;
      if (bus.new_packet) begin
        fe_d          = 1'b1;
        hold_d[23:16] = bus.data_in;
        state_d       = B1;
      end else if (state_q == B1) begin
        hold_d[15:8] = bus.data_in;
        state_d      = B2;
      end else if (state_q == B2) begin
        hold_d[7:0] = bus.data_in;
        state_d     = B3;
      end else begin
        push    = 1'b1;
        state_d = IDLE;
      end
    end else if (idle_q == TO_LAST) begin
      fe_d    = 1'b1;
      idle_d  = '0;
      state_d = IDLE;
    end else begin
      idle_d = idle_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idle_q  <= '0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idle_q  <= idle_d;
      fe_q    <= fe_d;
    end
  end

  assign pop = (cnt_q != 2'd0) && bus.output_ready;

  // Two-entry FIFO, ent0 is always the head; simultaneous push+pop never overruns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= push && (cnt_q == 2'd2) && !pop;
      case (cnt_q)
        2'd0: begin
          if (push) begin
            ent0_q <= push_word;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            ent0_q <= push_word;
          end else if (push) begin
            ent1_q <= push_word;
            cnt_q  <= 2'd2;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            ent0_q <= ent1_q;
            if (push) ent1_q <= push_word;
            else      cnt_q  <= 2'd1;
          end
        end
      endcase
    end
  end

  assign bus.data_ready  = (cnt_q != 2'd0);
  assign bus.stock_data  = (cnt_q != 2'd0) ? ent0_q : 32'h0;
  assign bus.overrun     = ovr_q;
  assign bus.frame_error = fe_q;

endmodule

// File: tb/tb_usb_rx_word_assembler.sv
// Randomized and directed checks of the word assembler against a queue-based
// byte-count model evaluated once per clock.
module tb_usb_rx_word_assembler;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_rx_word_assembler_if bus ();

  usb_rx_word_assembler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: bytes collected so far, partial word, idle count, output queue
  int          m_n;
  logic [31:0] m_word;
  int          m_idle;
  logic [31:0] m_q[$];
  logic        m_ovr, m_fe;

  task automatic model_reset();
    m_n = 0; m_word = 0; m_idle = 0; m_q.delete(); m_ovr = 0; m_fe = 0;
  endtask

  task automatic model_tick();
    bit pop, push;
    logic [31:0] w;
    pop = (m_q.size() > 0) && bus.output_ready;
    push = 0; w = 0; m_ovr = 0; m_fe = 0;
    if (bus.byte_valid) begin
      if (bus.new_packet) begin
        if (m_n > 0) m_fe = 1;
        m_word = {bus.data_in, 24'h0}; m_n = 1; m_idle = 0;
      end else if (m_n == 0) begin
        m_fe = 1;
      end else begin
        m_word = m_word | (32'(bus.data_in) << (8 * (3 - m_n)));
        m_n++; m_idle = 0;
        if (m_n == 4) begin push = 1; w = m_word; m_n = 0; end
      end
    end else if (m_n > 0) begin
      m_idle++;
      if (m_idle == TO) begin m_fe = 1; m_n = 0; m_idle = 0; end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 2) m_q.push_back(w);
      else m_ovr = 1;
    end
  endtask

  function automatic logic [34:0] exp_vec();
    logic [31:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 32'h0;
    return {m_q.size() > 0, h, m_ovr, m_fe};
  endfunction

  task automatic step(input bit bv, input bit np, input logic [7:0] d, input bit ordy);
    bus.byte_valid = bv; bus.new_packet = np; bus.data_in = d; bus.output_ready = ordy;
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic test_reset();
    bus.byte_valid = 0; bus.new_packet = 0; bus.data_in = 0; bus.output_ready = 0;
    rst = 0;
    #1 rst = 1;
    #1;
    n_tests++; if ({bus.data_ready, bus.stock_data, bus.overrun, bus.frame_error} !== 35'h0) begin
      n_fail++; $display("FAIL reset_async got %h want 0", {bus.data_ready, bus.stock_data, bus.overrun, bus.frame_error}); end
    step(1, 1, 8'h55, 1);
    step(1, 0, 8'h66, 1);
    n_tests++; if ({bus.data_ready, bus.stock_data, bus.overrun, bus.frame_error} !== 35'h0) begin
      n_fail++; $display("FAIL reset_held got %h want 0", {bus.data_ready, bus.stock_data, bus.overrun, bus.frame_error}); end
    rst = 0;
    model_reset();
  endtask

  task automatic test_deadbeef();
    step(1, 1, 8'hDE, 1); step(1, 0, 8'hAD, 1); step(1, 0, 8'hBE, 1);
    n_tests++; if (bus.data_ready !== 1'b0) begin
      n_fail++; $display("FAIL deadbeef_early got %b want 0", bus.data_ready); end
    step(1, 0, 8'hEF, 1);
    n_tests++; if (bus.data_ready !== 1'b1 || bus.stock_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL deadbeef_word got %b/%h want 1/deadbeef", bus.data_ready, bus.stock_data); end
    step(0, 0, 8'h00, 1);
    n_tests++; if (bus.data_ready !== 1'b0 || bus.stock_data !== 32'h0) begin
      n_fail++; $display("FAIL deadbeef_pop got %b/%h want 0/0", bus.data_ready, bus.stock_data); end
  endtask

  task automatic test_overrun();
    logic [31:0] words [3] = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
    logic [31:0] w;
    int ovr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        step(1, b == 0, w[31 - 8 * b -: 8], 0);
        if (bus.overrun === 1'b1) ovr_cnt++;
      end
    end
    n_tests++; if (bus.overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_pulse got %b want 1", bus.overrun); end
    step(0, 0, 8'h00, 0);
    if (bus.overrun === 1'b1) ovr_cnt++;
    n_tests++; if (ovr_cnt != 1) begin
      n_fail++; $display("FAIL overrun_count got %0d want 1", ovr_cnt); end
    n_tests++; if (bus.stock_data !== 32'h01020304) begin
      n_fail++; $display("FAIL overrun_head0 got %h want 01020304", bus.stock_data); end
    step(0, 0, 8'h00, 1);
    n_tests++; if (bus.data_ready !== 1'b1 || bus.stock_data !== 32'h05060708) begin
      n_fail++; $display("FAIL overrun_head1 got %b/%h want 1/05060708", bus.data_ready, bus.stock_data); end
    step(0, 0, 8'h00, 1);
    n_tests++; if (bus.data_ready !== 1'b0) begin
      n_fail++; $display("FAIL overrun_drain got %b want 0", bus.data_ready); end
  endtask

  task automatic test_resync();
    logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bit np [6] = '{1, 0, 1, 0, 0, 0};
    int fe_cnt = 0;
    int dr_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, np[i], bytes[i], 1);
      if (bus.frame_error === 1'b1) fe_cnt++;
      if (bus.data_ready === 1'b1) dr_cnt++;
      if (i == 2) begin
        n_tests++; if (bus.frame_error !== 1'b1) begin
          n_fail++; $display("FAIL resync_fe got %b want 1", bus.frame_error); end
      end
    end
    n_tests++; if (fe_cnt != 1 || dr_cnt != 1) begin
      n_fail++; $display("FAIL resync_counts got fe=%0d words=%0d want 1/1", fe_cnt, dr_cnt); end
    n_tests++; if (bus.stock_data !== 32'h33445566) begin
      n_fail++; $display("FAIL resync_word got %h want 33445566", bus.stock_data); end
    step(0, 0, 8'h00, 1);
  endtask

  task automatic test_timeout();
    step(1, 1, 8'hAA, 1); step(1, 0, 8'hBB, 1);
    for (int i = 0; i < TO; i++) begin
      step(0, 0, 8'h00, 1);
      n_tests++; if (bus.frame_error !== (i == TO - 1)) begin
        n_fail++; $display("FAIL timeout_idle%0d got %b want %b", i, bus.frame_error, i == TO - 1); end
    end
    step(0, 0, 8'h00, 1);
    n_tests++; if (bus.frame_error !== 1'b0) begin
      n_fail++; $display("FAIL timeout_single got %b want 0", bus.frame_error); end
    step(1, 0, 8'hCC, 1);
    n_tests++; if (bus.frame_error !== 1'b1 || bus.data_ready !== 1'b0) begin
      n_fail++; $display("FAIL timeout_stray got fe=%b dr=%b want 1/0", bus.frame_error, bus.data_ready); end
    step(0, 0, 8'h00, 1);
  endtask

  task automatic test_full_push_pop();
    logic [31:0] words [3] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) step(1, b == 0, w[31 - 8 * b -: 8], (i == 2) && (b == 3));
    end
    n_tests++; if (bus.overrun !== 1'b0 || bus.data_ready !== 1'b1 || bus.stock_data !== 32'hB1B2B3B4) begin
      n_fail++; $display("FAIL fullpp_swap got ovr=%b dr=%b %h want 0/1/b1b2b3b4", bus.overrun, bus.data_ready, bus.stock_data); end
    step(0, 0, 8'h00, 1);
    n_tests++; if (bus.stock_data !== 32'hC1C2C3C4) begin
      n_fail++; $display("FAIL fullpp_tail got %h want c1c2c3c4", bus.stock_data); end
    step(0, 0, 8'h00, 1);
    n_tests++; if (bus.data_ready !== 1'b0) begin
      n_fail++; $display("FAIL fullpp_drain got %b want 0", bus.data_ready); end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 8'h10, 0); step(1, 0, 8'h20, 0); step(1, 0, 8'h30, 0); step(1, 0, 8'h40, 0);
    step(1, 1, 8'h50, 0); step(1, 0, 8'h60, 0);
    bus.byte_valid = 0;
    rst = 1;
    #1;
    n_tests++; if ({bus.data_ready, bus.stock_data, bus.overrun, bus.frame_error} !== 35'h0) begin
      n_fail++; $display("FAIL rstmid_async got %h want 0", {bus.data_ready, bus.stock_data, bus.overrun, bus.frame_error}); end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    n_tests++; if ({bus.data_ready, bus.overrun, bus.frame_error} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_pulse got %b want 000", {bus.data_ready, bus.overrun, bus.frame_error}); end
    step(1, 1, 8'h71, 1);
    n_tests++; if (bus.frame_error !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_first got %b want 0", bus.frame_error); end
    step(1, 0, 8'h82, 1); step(1, 0, 8'h93, 1); step(1, 0, 8'hA4, 1);
    n_tests++; if (bus.data_ready !== 1'b1 || bus.stock_data !== 32'h718293A4) begin
      n_fail++; $display("FAIL rstmid_word got %b/%h want 1/718293a4", bus.data_ready, bus.stock_data); end
    step(0, 0, 8'h00, 1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    int words = 0;
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        step(1, b == 0, w[31 - 8 * b -: 8], 1);
        if (bus.data_ready === 1'b1) words++;
      end
      n_tests++; if (bus.data_ready !== 1'b1 || bus.stock_data !== w) begin
        n_fail++; $display("FAIL b2b_word%0d got %b/%h want 1/%h", i, bus.data_ready, bus.stock_data, w); end
    end
    n_tests++; if (words != 3) begin
      n_fail++; $display("FAIL b2b_count got %0d want 3", words); end
    step(0, 0, 8'h00, 1);
  endtask

  task automatic test_random();
    bit bv, np, ordy;
    logic [34:0] act, exp;
    int errs = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        bv = 0; np = 0;
      end else begin
        bv = $urandom_range(0, 9) < 7;
        np = (m_n == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 11) == 0);
      end
      ordy = $urandom_range(0, 2) == 0;
      if (c % 50 < 6) begin bv = 0; np = 0; end
      step(bv, np, 8'($urandom), ordy);
      act = {bus.data_ready, bus.stock_data, bus.overrun, bus.frame_error};
      exp = exp_vec();
      n_tests++; if (act !== exp) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL random_c%0d got %h want %h", c, act, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_deadbeef();
    test_overrun();
    test_resync();
    test_timeout();
    test_full_push_pop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
